data_mem_responder: RTL

//  Responder end of the MEM-stage data-memory interface: accepts load/store requests from the

---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_if.sv | 26 ++
 rtl/data_mem_responder_word_array.sv | 32 +++
 rtl/data_mem_responder.sv | 134 +++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM state encoding
// and the word-index width helper used by the MEM-stage and hazard logic.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  reqValid;
    logic                  writeEnable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  reqReady;
    logic                  respValid;
    logic [DATA_WIDTH-1:0] readData;
    logic                  addrError;
    logic                  stallOut;
    logic [DATA_WIDTH-1:0] testData;

    modport master (
        output reqValid, writeEnable, addr, writeData,
        input  reqReady, respValid, readData, addrError, stallOut, testData
    );

    modport slave (
        input  reqValid, writeEnable, addr, writeData,
        output reqReady, respValid, readData, addrError, stallOut, testData
    );
endinterface

// File: rtl/data_mem_responder_word_array.sv
// Register-based word array: synchronous write, async-reset clear,
// combinational read port and a fixed tap on word 0.
module dm_word_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [idx_width(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic [idx_width(DEPTH)-1:0]   rd_idx,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [DATA_WIDTH-1:0]         word0
);
    logic [DATA_WIDTH-1:0] words [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];
    assign word0   = words[0];
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface: stores complete in one cycle,
// loads return after READ_LATENCY cycles while the pipeline is back-pressured.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DEPTH        = 128,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned IW = idx_width(DEPTH);
    localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    state_t                  state, state_next;
    logic [CW-1:0]           count, count_next;
    logic [IW-1:0]           load_idx, load_idx_next;
    logic                    load_err, load_err_next;
    logic                    resp_valid, resp_valid_next;
    logic                    addr_error, addr_error_next;
    logic [DATA_WIDTH-1:0]   read_data, read_data_next;

    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IW-1:0]           req_idx;
    logic [IW-1:0]           rd_idx;
    logic                    addr_bad;
    logic                    accept;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   arr_rd_data;
    logic [DATA_WIDTH-1:0]   word0;

    assign word_addr = bus.addr >> 2;
    assign addr_bad  = (bus.addr[1:0] != 2'b00) || (word_addr >= ADDR_WIDTH'(DEPTH));
    assign req_idx   = word_addr[IW-1:0];
    assign accept    = bus.reqValid && (state == IDLE);
    assign wr_en     = accept && bus.writeEnable && !addr_bad;

    // With a single-cycle latency the capture happens on the accepting edge,
    // so the read port must see the incoming index rather than the latched one.
    assign rd_idx = (state == IDLE) ? req_idx : load_idx;

    dm_word_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_data (bus.writeData),
        .rd_idx  (rd_idx),
        .rd_data (arr_rd_data),
        .word0   (word0)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            load_idx   <= '0;
            load_err   <= 1'b0;
            resp_valid <= 1'b0;
            addr_error <= 1'b0;
            read_data  <= '0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            load_idx   <= load_idx_next;
            load_err   <= load_err_next;
            resp_valid <= resp_valid_next;
            addr_error <= addr_error_next;
            read_data  <= read_data_next;
        end
    end

    always_comb begin
        state_next      = state;
        count_next      = count;
        load_idx_next   = load_idx;
        load_err_next   = load_err;
        resp_valid_next = 1'b0;
        addr_error_next = 1'b0;
        read_data_next  = read_data;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.writeEnable) begin
                        resp_valid_next = 1'b1;
                        addr_error_next = addr_bad;
                    end else begin
                        load_idx_next = req_idx;
                        load_err_next = addr_bad;
                        count_next    = CW'(READ_LATENCY - 1);
                        if (READ_LATENCY == 1) begin
                            state_next      = RESP;
                            resp_valid_next = 1'b1;
                            addr_error_next = addr_bad;
                            read_data_next  = addr_bad ? '0 : arr_rd_data;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
            end
            BUSY: begin
                if (count == CW'(1)) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    addr_error_next = load_err;
                    read_data_next  = load_err ? '0 : arr_rd_data;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.reqReady  = (state == IDLE);
    assign bus.respValid = resp_valid;
    assign bus.readData  = read_data;
    assign bus.addrError = addr_error;
    assign bus.stallOut  = bus.reqValid && (state != IDLE);
    assign bus.testData  = word0;
endmodule
